// File: rtl/sig_lut_interp.sv
// Sigmoid LUT interpolator: drives LUT address from the integer nibble, blends base/next by the fraction.
// Two register stages (address/frac, then saturated result); valid/ready on both sides, full-rate streaming.
module sig_lut_interp #(
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int PW = DATA_W + FRAC_W + 2;
    localparam logic signed [PW-1:0] HALF    = PW'(2 ** (FRAC_W - 1));
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (DATA_W - 1)));

    logic              s1_valid;
    logic [FRAC_W-1:0] s1_frac;
    logic              s1_load;
    logic              s2_load;

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   step;
    logic signed [PW-1:0]   interp;
    logic [DATA_W-1:0]      sat;

    // in_ready must not depend on in_valid, so it is derived only from pipeline occupancy.
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;

    // Full-precision blend; only the final value is clamped to the output range.
    always_comb begin
        diff   = {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
        prod   = PW'(diff) * PW'($signed({1'b0, s1_frac}));
        step   = (prod + HALF) >>> FRAC_W;
        interp = PW'($signed(lut_base)) + step;
        sat    = interp[DATA_W-1:0];
        if (interp > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (interp < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            lut_addr <= '0;
            s1_frac  <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            lut_addr <= in_data[DATA_W-1:FRAC_W];
            s1_frac  <= in_data[FRAC_W-1:0];
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
